// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master arbiter.
package apb_pkg;

    // Phases of a single APB transfer as driven by the master.
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter: rotate-priority search starting one past the last
// winner, with the pointer advanced only when a grant is actually taken.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] cand;

    // First requester found scanning from ptr+1 upward, wrapping at NUM_REQ.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any_grant && req[cand]) begin
                any_grant = 1'b1;
                grant_idx = cand;
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Pointer remembers the last accepted requester; reset value makes
    // requester 0 the first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= IDX_W'(NUM_REQ - 1);
        end else if (update) begin
            ptr <= grant_idx;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between NUM_REQ requesters. A round-robin
// arbiter picks a command, the IDLE/SETUP/ACCESS FSM runs one APB transfer,
// and the result is returned as a one-cycle rsp_valid pulse to the owner.
//
// Command handshake: a command transfers at a rising edge where
// req_valid[i] & req_ready[i]. While valid and not ready the requester holds
// req_write/req_addr/req_wdata stable and may not drop req_valid. req_ready
// is one-hot or zero and is only offered in IDLE and ACCESS.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    output apb_state_e                dbg_state
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    apb_state_e         state;
    apb_state_e         next_state;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;
    logic               arb_open;
    logic               accept;
    logic [IDX_W-1:0]   owner;

    // Arbitration is offered whenever the bus can take a new SETUP next cycle.
    assign arb_open  = (state != APB_SETUP);
    assign accept    = arb_open & any_grant;
    assign req_ready = arb_open ? grant : '0;
    assign dbg_state = state;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (pclk),
        .rst_n     (presetn),
        .req       (req_valid),
        .update    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // FSM state register; async reset drops psel/penable immediately.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= APB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and APB control strobes.
    always_comb begin
        next_state = state;
        psel       = 1'b0;
        penable    = 1'b0;
        case (state)
            APB_IDLE: begin
                if (accept) next_state = APB_SETUP;
            end
            APB_SETUP: begin
                psel       = 1'b1;
                next_state = APB_ACCESS;
            end
            APB_ACCESS: begin
                psel       = 1'b1;
                penable    = 1'b1;
                next_state = accept ? APB_SETUP : APB_IDLE;
            end
            default: begin
                next_state = APB_IDLE;
            end
        endcase
    end

    // Latch the winning command; the bus fields only move on entry to SETUP.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
            owner  <= '0;
        end else if (accept) begin
            paddr  <= req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
            pwrite <= req_write[grant_idx];
            pwdata <= req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
            owner  <= grant_idx;
        end
    end

    // Completion: capture read data at the end of ACCESS and pulse the owner.
    // owner is read before a same-edge accept overwrites it.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (state == APB_ACCESS) begin
                rsp_valid[owner] <= 1'b1;
                rsp_rdata        <= pwrite ? '0 : prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed vector table, a hand-written
// reset-during-ACCESS sequence, then randomized traffic against a
// transaction-level model.
module tb_apb_master_arbiter;
    import apb_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            pclk;
    logic            presetn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            psel;
    logic            penable;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    apb_state_e      dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    // ---------------- clock / reset ----------------
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    apb_master_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .psel      (psel),
        .penable   (penable),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .dbg_state (dbg_state)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic [N-1:0]  valid;
        logic [N-1:0]  write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] prd;
        logic [N-1:0]  e_ready;
        logic          e_psel;
        logic          e_pen;
        logic [AW-1:0] e_paddr;
        logic          e_pwrite;
        logic [DW-1:0] e_pwdata;
        logic [N-1:0]  e_rsp;
        logic [DW-1:0] e_rdata;
    } vec_t;

    localparam int NV = 30;
    vec_t tv[NV];

    function automatic vec_t mk(logic rst, logic [N-1:0] v, logic [N-1:0] w,
                                logic [AW-1:0] a, logic [DW-1:0] wd, logic [DW-1:0] pr,
                                logic [N-1:0] er, logic es, logic ee, logic [AW-1:0] ea,
                                logic ew, logic [DW-1:0] ewd, logic [N-1:0] erv,
                                logic [DW-1:0] erd);
        vec_t t;
        t.rst = rst; t.valid = v; t.write = w; t.addr = a; t.wdata = wd; t.prd = pr;
        t.e_ready = er; t.e_psel = es; t.e_pen = ee; t.e_paddr = ea; t.e_pwrite = ew;
        t.e_pwdata = ewd; t.e_rsp = erv; t.e_rdata = erd;
        return t;
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] er, input logic es,
                             input logic ee, input logic [AW-1:0] ea, input logic ew,
                             input logic [DW-1:0] ewd, input logic [N-1:0] erv,
                             input logic [DW-1:0] erd);
        check({tag, ".req_ready"}, 64'(req_ready), 64'(er));
        check({tag, ".psel"},      64'(psel),      64'(es));
        check({tag, ".penable"},   64'(penable),   64'(ee));
        check({tag, ".paddr"},     64'(paddr),     64'(ea));
        check({tag, ".pwrite"},    64'(pwrite),    64'(ew));
        check({tag, ".pwdata"},    64'(pwdata),    64'(ewd));
        check({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(erv));
        check({tag, ".rsp_rdata"}, 64'(rsp_rdata), 64'(erd));
    endtask

    task automatic drive_all(input logic [N-1:0] v, input logic [N-1:0] w,
                             input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req_valid = v;
        req_write = w;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a;
            req_wdata[i*DW +: DW] = wd;
        end
    endtask

    // ---------------- reference model (random phase) ----------------
    logic [N-1:0]  r_valid;
    logic [N-1:0]  r_write;
    logic [AW-1:0] r_addr[N];
    logic [DW-1:0] r_wdata[N];

    int            m_ptr;
    int            m_age;      // cycles since the last accepted command
    int            m_owner;
    logic [AW-1:0] m_addr;
    logic          m_write;
    logic [DW-1:0] m_wdata;
    int            m_rsp_owner;
    logic [DW-1:0] m_last;
    logic [DW-1:0] exp_q[$];

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        string tag;
        int win;
        int load;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rsp;
        logic [DW-1:0] e_rdata;

        presetn = 1'b0;
        prdata  = '0;
        drive_all('0, '0, '0, '0);

        tv[0]  = mk(0, 4'h0, 4'h0, 32'h00, 32'h0,        32'h0,        4'h0, 0, 0, 32'h00, 0, 32'h0,        4'h0, 32'h0);
        tv[1]  = mk(1, 4'h1, 4'h1, 32'h10, 32'hDEADBEEF, 32'h0,        4'h1, 0, 0, 32'h00, 0, 32'h0,        4'h0, 32'h0);
        tv[2]  = mk(1, 4'h0, 4'h1, 32'h10, 32'hDEADBEEF, 32'h0,        4'h0, 1, 0, 32'h10, 1, 32'hDEADBEEF, 4'h0, 32'h0);
        tv[3]  = mk(1, 4'h0, 4'h1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF, 4'h0, 1, 1, 32'h10, 1, 32'hDEADBEEF, 4'h0, 32'h0);
        tv[4]  = mk(1, 4'h0, 4'h0, 32'h10, 32'hDEADBEEF, 32'h0,        4'h0, 0, 0, 32'h10, 1, 32'hDEADBEEF, 4'h1, 32'h0);
        tv[5]  = mk(1, 4'h4, 4'h0, 32'h20, 32'h0,        32'h0,        4'h4, 0, 0, 32'h10, 1, 32'hDEADBEEF, 4'h0, 32'h0);
        tv[6]  = mk(1, 4'h0, 4'h0, 32'h20, 32'h0,        32'h0,        4'h0, 1, 0, 32'h20, 0, 32'h0,        4'h0, 32'h0);
        tv[7]  = mk(1, 4'h0, 4'h0, 32'h20, 32'h0,        32'h12345678, 4'h0, 1, 1, 32'h20, 0, 32'h0,        4'h0, 32'h0);
        tv[8]  = mk(1, 4'h0, 4'h0, 32'h20, 32'h0,        32'h0,        4'h0, 0, 0, 32'h20, 0, 32'h0,        4'h4, 32'h12345678);
        tv[9]  = mk(0, 4'h0, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 0, 0, 32'h00, 0, 32'h0,        4'h0, 32'h0);
        tv[10] = mk(1, 4'hF, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h1, 0, 0, 32'h00, 0, 32'h0,        4'h0, 32'h0);
        tv[11] = mk(1, 4'hE, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[12] = mk(1, 4'hE, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h2, 1, 1, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[13] = mk(1, 4'hC, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h1, 32'h0);
        tv[14] = mk(1, 4'hC, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h4, 1, 1, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[15] = mk(1, 4'h8, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h2, 32'h0);
        tv[16] = mk(1, 4'h8, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h8, 1, 1, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[17] = mk(1, 4'hA, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h4, 32'h0);
        tv[18] = mk(1, 4'hA, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h2, 1, 1, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[19] = mk(1, 4'h8, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h8, 32'h0);
        tv[20] = mk(1, 4'h8, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h8, 1, 1, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[21] = mk(1, 4'h0, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h2, 32'h0);
        tv[22] = mk(1, 4'h0, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 1, 1, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[23] = mk(1, 4'h0, 4'hF, 32'h30, 32'hA5A5A5A5, 32'h0,        4'h0, 0, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h8, 32'h0);
        tv[24] = mk(1, 4'h1, 4'h0, 32'h40, 32'h11112222, 32'h0,        4'h1, 0, 0, 32'h30, 1, 32'hA5A5A5A5, 4'h0, 32'h0);
        tv[25] = mk(1, 4'h8, 4'h0, 32'h50, 32'h33334444, 32'h0,        4'h0, 1, 0, 32'h40, 0, 32'h11112222, 4'h0, 32'h0);
        tv[26] = mk(1, 4'h8, 4'h0, 32'h50, 32'h33334444, 32'hCAFE0001, 4'h8, 1, 1, 32'h40, 0, 32'h11112222, 4'h0, 32'h0);
        tv[27] = mk(1, 4'h0, 4'h0, 32'h50, 32'h33334444, 32'h0,        4'h0, 1, 0, 32'h50, 0, 32'h33334444, 4'h1, 32'hCAFE0001);
        tv[28] = mk(1, 4'h0, 4'h0, 32'h50, 32'h33334444, 32'hBEEF0002, 4'h0, 1, 1, 32'h50, 0, 32'h33334444, 4'h0, 32'hCAFE0001);
        tv[29] = mk(1, 4'h0, 4'h0, 32'h50, 32'h33334444, 32'h0,        4'h0, 0, 0, 32'h50, 0, 32'h33334444, 4'h8, 32'hBEEF0002);

        // Directed table: inputs applied after a rising edge, outputs
        // compared on the falling edge of the same cycle.
        for (int j = 0; j < NV; j++) begin
            @(posedge pclk); #1;
            presetn = tv[j].rst;
            prdata  = tv[j].prd;
            drive_all(tv[j].valid, tv[j].write, tv[j].addr, tv[j].wdata);
            @(negedge pclk);
            tag = $sformatf("v%0d", j);
            check_all(tag, tv[j].e_ready, tv[j].e_psel, tv[j].e_pen, tv[j].e_paddr,
                      tv[j].e_pwrite, tv[j].e_pwdata, tv[j].e_rsp, tv[j].e_rdata);
        end

        // Reset during ACCESS: strobes drop at once, no response, pointer reset.
        @(posedge pclk); #1;
        drive_all(4'h1, 4'h1, 32'h60, 32'h77);
        @(negedge pclk);
        check("rst.ready_idle", 64'(req_ready), 64'h1);
        @(posedge pclk); #1;
        drive_all(4'h0, 4'h1, 32'h60, 32'h77);
        @(negedge pclk);
        check("rst.setup_psel", 64'(psel), 64'h1);
        @(posedge pclk); #1;
        check("rst.access_pen", 64'(penable), 64'h1);
        presetn = 1'b0;
        #1;
        check("rst.async_psel",  64'(psel),    64'h0);
        check("rst.async_pen",   64'(penable), 64'h0);
        check("rst.async_paddr", 64'(paddr),   64'h0);
        @(negedge pclk);
        check("rst.no_rsp0", 64'(rsp_valid), 64'h0);
        @(posedge pclk); #1;
        presetn = 1'b1;
        drive_all(4'h3, 4'h0, 32'h70, 32'h0);
        @(negedge pclk);
        check("rst.no_rsp1",   64'(rsp_valid), 64'h0);
        check("rst.ptr_reset", 64'(req_ready), 64'h1);
        @(posedge pclk); #1;
        drive_all(4'h2, 4'h0, 32'h70, 32'h0);
        @(negedge pclk);
        check("rst.setup_ready", 64'(req_ready), 64'h0);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("rst.req1_grant", 64'(req_ready), 64'h2);
        @(posedge pclk); #1;
        drive_all(4'h0, 4'h0, 32'h70, 32'h0);
        @(negedge pclk);
        check("rst.rsp_req0", 64'(rsp_valid), 64'h1);
        @(posedge pclk); #1;
        @(negedge pclk);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("rst.rsp_req1", 64'(rsp_valid), 64'h2);

        // Randomized traffic against the transaction-level model.
        @(posedge pclk); #1;
        presetn = 1'b0;
        drive_all('0, '0, '0, '0);
        r_valid = '0;
        r_write = '0;
        for (int i = 0; i < N; i++) begin
            r_addr[i]  = '0;
            r_wdata[i] = '0;
        end
        m_ptr = N - 1; m_age = 10; m_owner = 0;
        m_addr = '0; m_write = 1'b0; m_wdata = '0;
        m_rsp_owner = -1; m_last = '0;
        exp_q.delete();
        @(posedge pclk); #1;
        presetn = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge pclk); #1;
            req_valid = r_valid;
            req_write = r_write;
            for (int i = 0; i < N; i++) begin
                req_addr[i*AW +: AW]  = r_addr[i];
                req_wdata[i*DW +: DW] = r_wdata[i];
            end
            prdata = $urandom;
            @(negedge pclk);

            // Expected outputs for this cycle.
            win     = (m_age != 1) ? rr_pick(m_ptr, r_valid) : -1;
            e_ready = (win >= 0) ? N'(1 << win) : '0;
            if (m_rsp_owner >= 0) begin
                e_rsp   = N'(1 << m_rsp_owner);
                e_rdata = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                m_last  = e_rdata;
            end else begin
                e_rsp   = '0;
                e_rdata = m_last;
            end
            tag = $sformatf("rnd%0d", c);
            check_all(tag, e_ready, (m_age == 1 || m_age == 2), (m_age == 2),
                      m_addr, m_write, m_wdata, e_rsp, e_rdata);

            // Transfer completing at this edge answers its owner next cycle.
            if (m_age == 2) begin
                m_rsp_owner = m_owner;
                exp_q.push_back(m_write ? '0 : prdata);
            end else begin
                m_rsp_owner = -1;
            end
            if (win >= 0) begin
                m_owner = win;
                m_ptr   = win;
                m_addr  = r_addr[win];
                m_write = r_write[win];
                m_wdata = r_wdata[win];
                m_age   = 1;
                r_valid[win] = 1'b0;
            end else if (m_age < 10) begin
                m_age++;
            end

            // Requesters with nothing pending may raise a new command.
            load = ((c / 500) % 2 == 0) ? 85 : 20;
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i] && ($urandom_range(0, 99) < load)) begin
                    r_valid[i] = 1'b1;
                    r_write[i] = 1'($urandom_range(0, 1));
                    r_addr[i]  = $urandom;
                    r_wdata[i] = $urandom;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Shares one APB master port between NUM_REQ local requesters, each with a valid/ready command channel.
- Round-robin arbiter picks one request; an IDLE/SETUP/ACCESS FSM runs a single APB transfer (no pready, so wait states are not supported).
- Returns read data or write acknowledge to the winning requester.
- Sits between bus-master agents (DMA, CPU bridge, test sequencers) and the APB master side of the shared APB interface (psel, penable, paddr, pwrite, pwdata, prdata).

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- ADDR_W, 32, paddr / req_addr width
- DATA_W, 32, pwdata / prdata / req_wdata width

Ports:
- pclk  in  1  APB clock; all logic on rising edge
- presetn  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester command valid
- req_ready  out  NUM_REQ  per-requester command accepted (one-hot or zero)
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
- rsp_rdata  out  DATA_W  captured prdata; 0 for writes
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  ADDR_W  APB address
- pwrite  out  1  APB direction
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data

Behaviour:
- Reset (presetn low, asynchronous):
  - FSM goes to IDLE.
  - psel, penable, paddr, pwrite, pwdata, rsp_valid and rsp_rdata are all 0.
  - RR pointer = NUM_REQ-1, so requester 0 has top priority first.
- Arbitration:
  - Evaluated combinationally only in states IDLE and ACCESS.
  - Winner = first requester with req_valid set, searching from pointer+1 upward with wrap-around modulo NUM_REQ.
  - req_ready[winner] = 1 in that cycle; all other req_ready bits are 0.
  - In SETUP, req_ready = 0.
- Handshake:
  - Accept occurs at the rising edge where req_valid[i] & req_ready[i].
  - Requester must hold req_write, req_addr and req_wdata stable while valid and not ready, and may not withdraw valid before acceptance.
  - On accept: latch command and owner index; pointer <= i.
- FSM:
  - IDLE: psel=0, penable=0. Accept → SETUP; otherwise stay.
  - SETUP: psel=1, penable=0; paddr, pwrite, pwdata driven from the latched command. Always → ACCESS.
  - ACCESS: psel=1, penable=1, same address/control/data.
    - At the end-of-ACCESS edge, capture rsp_rdata <= pwrite ? 0 : prdata, and pulse rsp_valid[owner]=1 in the following cycle.
    - If an accept happens in the same cycle → SETUP (back-to-back); else → IDLE.
- Latency: accept edge k → SETUP cycle k+1, ACCESS cycle k+2, rsp_valid high cycle k+3. Sustained throughput is 1 transfer per 2 cycles.
- Bus stability:
  - paddr, pwrite and pwdata change only on entry to SETUP.
  - In IDLE they hold the last values while psel=0.
  - penable never rises without psel having been high the previous cycle.
- Simultaneous events:
  - The rsp_valid pulse for transfer n coincides with the SETUP of transfer n+1. Both are legal; rsp_valid depends only on the owner of transfer n.
  - The completing requester may be re-granted in ACCESS only if no higher-RR requester is valid.
- Reset mid-transfer:
  - psel/penable drop asynchronously.
  - No rsp_valid is emitted for the aborted transfer.
  - The latched command is discarded.

Decomposition:
- apb_pkg holds:
  - typedef enum logic [1:0] apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS};
  - default width constants APB_ADDR_W=32, APB_DATA_W=32.
- Sub-module apb_rr_arbiter (parameter NUM_REQ) contains:
  - combinational rotate-priority encoder: req vector + pointer → one-hot grant and index;
  - registered pointer update on an enable input.
- The FSM and datapath stay in the top module.

Test Plan:
1. Single write: req0 addr 0x0000_0010, wdata 0xDEAD_BEEF → SETUP cycle (psel=1, penable=0) with those values, then ACCESS; rsp_valid[0] one cycle later with rsp_rdata=0.
2. Single read: req2 addr 0x20; slave drives prdata=0x1234_5678 in ACCESS → rsp_valid[2] pulse with rsp_rdata=0x1234_5678; no other rsp_valid bit set.
3. Round-robin: all 4 requesters valid from reset → grant order 0,1,2,3,0. Transfers run back-to-back: psel stays high, penable toggles 0/1 every cycle, and there are no IDLE cycles.
4. Pointer wrap: last grant=3, then only req1 and req3 valid → req1 granted before req3.
5. Reset mid-ACCESS: assert presetn low during ACCESS → psel/penable are 0 immediately, no rsp_valid. After release with req1 valid, the next grant goes to req1 with the pointer at NUM_REQ-1.
6. Stall hold: req3 valid while req0's transfer is in SETUP → req_ready[3]=0 during SETUP; the request is accepted at ACCESS, with paddr stable from SETUP through ACCESS for each transfer.
